// File: rtl/pwm_multi_pkg.sv
// Shared register map and helpers for the multi-channel PWM peripheral.
package pwm_multi_pkg;

   localparam int unsigned REG_CTRL   = 0;
   localparam int unsigned REG_STATUS = 1;
   localparam int unsigned REG_IRQ_EN = 2;
   localparam int unsigned REG_INFO   = 3;
   localparam int unsigned CH_BASE    = 4;

   localparam logic [15:0] INFO_LO = 16'h0000;

   // Word index of PERIOD_i (is_duty=0) or DUTY_i (is_duty=1).
   function automatic int unsigned ch_reg_idx(input int unsigned i, input logic is_duty);
      return CH_BASE + 2 * i + 32'(is_duty);
   endfunction

   function automatic logic [31:0] info_word(input int unsigned w, input int unsigned ch);
      return {w[7:0], ch[7:0], INFO_LO};
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: wrapping counter, shadow period/duty applied at wrap,
// registered compare output and carry-out.
module pwm_channel #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         inv,
   input  logic [W-1:0] per_prog,
   input  logic [W-1:0] duty_prog,
   output logic         pwm,
   output logic         co,
   output logic         co_nxt
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] per_a_q, per_a_d;
   logic [W-1:0] duty_a_q, duty_a_d;
   logic         pwm_q, pwm_d;
   logic         co_q, co_d;
   logic         last;

   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      cnt_d    = cnt_q;
      per_a_d  = per_a_q;
      duty_a_d = duty_a_q;
      pwm_d    = inv;
      co_d     = 1'b0;
      last     = (per_a_q != '0) && (cnt_q == per_a_q - W'(1));

      if (!en || per_a_q == '0) begin
         // Parked: shadows keep tracking the programmed values, so enabling
         // (or leaving a zero period) starts from the current settings.
         cnt_d    = '0;
         per_a_d  = per_prog;
         duty_a_d = duty_prog;
      end else begin
         pwm_d = (cnt_q < duty_a_q) ^ inv;
         co_d  = last;
         if (last) begin
            cnt_d    = '0;
            per_a_d  = per_prog;
            duty_a_d = duty_prog;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         per_a_q  <= '0;
         duty_a_q <= '0;
         pwm_q    <= 1'b0;
         co_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so all flops sample pre-edge values together.
         cnt_q    <= cnt_d;
         per_a_q  <= per_a_d;
         duty_a_q <= duty_a_d;
         pwm_q    <= pwm_d;
         co_q     <= co_d;
      end
   end

   assign pwm    = pwm_q;
   assign co     = co_q;
   assign co_nxt = co_d;

endmodule

// File: rtl/pwm_multi_periph.sv
// Multi-channel PWM peripheral on the PicoMem slave bus: register file,
// registered read mux, sticky carry-out status and maskable interrupt.
module pwm_multi_periph
   import pwm_multi_pkg::*;
#(
   parameter int unsigned CH     = 4,
   parameter int unsigned W      = 32,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              write,
   input  logic [31:0]       wrdata,
   output logic [31:0]       rddata,
   output logic [CH-1:0]     pwm,
   output logic [CH-1:0]     co,
   output logic              irq
);

   logic [31:0]     widx;
   logic [2*CH-1:0] ctrl_q, ctrl_d;
   logic [CH-1:0]   status_q, status_d;
   logic [CH-1:0]   irq_en_q, irq_en_d;
   logic [W-1:0]    per_q [CH];
   logic [W-1:0]    per_d [CH];
   logic [W-1:0]    duty_q [CH];
   logic [W-1:0]    duty_d [CH];
   logic [31:0]     rddata_q, rddata_d;
   logic [CH-1:0]   w1c;
   logic [CH-1:0]   co_set;
   logic            unused_bits;

   assign widx        = 32'(addr[ADDR_W-1:2]);
   assign unused_bits = ^{addr[1:0], wrdata};

   always_comb begin
      ctrl_d   = ctrl_q;
      irq_en_d = irq_en_q;
      per_d    = per_q;
      duty_d   = duty_q;
      w1c      = '0;
      if (write) begin
         if (widx == REG_CTRL)   ctrl_d   = wrdata[2*CH-1:0];
         if (widx == REG_STATUS) w1c      = wrdata[CH-1:0];
         if (widx == REG_IRQ_EN) irq_en_d = wrdata[CH-1:0];
         for (int unsigned i = 0; i < CH; i++) begin
            if (widx == ch_reg_idx(i, 1'b0)) per_d[i]  = wrdata[W-1:0];
            if (widx == ch_reg_idx(i, 1'b1)) duty_d[i] = wrdata[W-1:0];
         end
      end
      // A new carry-out on the same edge as a clear keeps the flag set.
      status_d = (status_q & ~w1c) | co_set;
   end

   always_comb begin
      rddata_d = '0;
      if (widx == REG_CTRL)   rddata_d = 32'(ctrl_q);
      if (widx == REG_STATUS) rddata_d = 32'(status_q);
      if (widx == REG_IRQ_EN) rddata_d = 32'(irq_en_q);
      if (widx == REG_INFO)   rddata_d = info_word(W, CH);
      for (int unsigned i = 0; i < CH; i++) begin
         if (widx == ch_reg_idx(i, 1'b0)) rddata_d = 32'(per_q[i]);
         if (widx == ch_reg_idx(i, 1'b1)) rddata_d = 32'(duty_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the register file is a handful of flops, not a RAM, so every entry is reset.
         ctrl_q   <= '0;
         status_q <= '0;
         irq_en_q <= '0;
         per_q    <= '{default: '0};
         duty_q   <= '{default: '0};
         rddata_q <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         status_q <= status_d;
         irq_en_q <= irq_en_d;
         per_q    <= per_d;
         duty_q   <= duty_d;
         rddata_q <= rddata_d;
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
      pwm_channel #(.W(W)) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (ctrl_q[g]),
         .inv       (ctrl_q[CH+g]),
         .per_prog  (per_q[g]),
         .duty_prog (duty_q[g]),
         .pwm       (pwm[g]),
         .co        (co[g]),
         .co_nxt    (co_set[g])
      );
   end

   assign rddata = rddata_q;
   assign irq    = |(status_q & irq_en_q);

endmodule

// File: tb/tb_pwm_multi_periph.sv
// Bench for pwm_multi_periph: directed bus stimulus, a per-cycle reference
// model of period position / shadows / status, and literal spot checks.
module tb_pwm_multi_periph;

   localparam int CH     = 4;
   localparam int W      = 32;
   localparam int ADDR_W = 8;

   localparam int I_CTRL = 0, I_STATUS = 1, I_IRQ_EN = 2, I_INFO = 3;
   localparam int I_P0 = 4, I_D0 = 5, I_P1 = 6, I_D1 = 7, I_UNMAPPED = 63;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic              write = 1'b0;
   logic [31:0]       wrdata = '0;
   logic [31:0]       rddata;
   logic [CH-1:0]     pwm;
   logic [CH-1:0]     co;
   logic              irq;

   always #5 clk = ~clk;

   pwm_multi_periph #(.CH(CH), .W(W), .ADDR_W(ADDR_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .addr   (addr),
      .write  (write),
      .wrdata (wrdata),
      .rddata (rddata),
      .pwm    (pwm),
      .co     (co),
      .irq    (irq)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
   endtask

   // Reference model: programmed registers, active shadows, and the position
   // inside the current period for each channel.
   bit [CH-1:0]  m_en, m_inv, m_status, m_irqen;
   logic [31:0]  m_per [CH];
   logic [31:0]  m_duty [CH];
   logic [31:0]  s_per [CH];
   logic [31:0]  s_duty [CH];
   longint       pos [CH];
   bit [CH-1:0]  want_pwm, want_co;
   logic [31:0]  want_rd;

   function automatic logic [31:0] model_read(input int idx);
      logic [31:0] info;
      info = {8'(W), 8'(CH), 16'h0};
      case (idx)
         I_CTRL:   return {24'd0, m_inv, m_en};
         I_STATUS: return {28'd0, m_status};
         I_IRQ_EN: return {28'd0, m_irqen};
         I_INFO:   return info;
         default: begin
            if (idx >= 4 && idx < 4 + 2 * CH)
               return ((idx - 4) % 2 == 0) ? m_per[(idx - 4) / 2] : m_duty[(idx - 4) / 2];
            return 32'd0;
         end
      endcase
   endfunction

   task automatic model_reset();
      m_en = '0; m_inv = '0; m_status = '0; m_irqen = '0;
      want_pwm = '0; want_co = '0; want_rd = '0;
      for (int c = 0; c < CH; c++) begin
         m_per[c] = '0; m_duty[c] = '0; s_per[c] = '0; s_duty[c] = '0; pos[c] = 0;
      end
   endtask

   task automatic model_step();
      int idx;
      idx = int'(addr[ADDR_W-1:2]);
      want_rd = model_read(idx);
      for (int c = 0; c < CH; c++) begin
         if (m_en[c] && s_per[c] != 0) begin
            // Inside the duty window the output sits at its active level.
            want_pwm[c] = (pos[c] < longint'(s_duty[c])) ? ~m_inv[c] : m_inv[c];
            want_co[c]  = (pos[c] + 1 == longint'(s_per[c]));
            if (want_co[c]) begin
               pos[c] = 0; s_per[c] = m_per[c]; s_duty[c] = m_duty[c];
            end else begin
               pos[c] = pos[c] + 1;
            end
         end else begin
            want_pwm[c] = m_inv[c];
            want_co[c]  = 1'b0;
            pos[c] = 0; s_per[c] = m_per[c]; s_duty[c] = m_duty[c];
         end
      end
      if (write && idx == I_STATUS) m_status = m_status & ~wrdata[CH-1:0];
      m_status = m_status | want_co;
      if (write) begin
         if (idx == I_CTRL) begin
            m_en  = wrdata[CH-1:0];
            m_inv = wrdata[2*CH-1:CH];
         end
         if (idx == I_IRQ_EN) m_irqen = wrdata[CH-1:0];
         if (idx >= 4 && idx < 4 + 2 * CH) begin
            if ((idx - 4) % 2 == 0) m_per[(idx - 4) / 2] = wrdata;
            else                    m_duty[(idx - 4) / 2] = wrdata;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Compare process: every output, every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         check("model_pwm", 32'(pwm), 32'(want_pwm));
         check("model_co", 32'(co), 32'(want_co));
         check("model_irq", 32'(irq), 32'(|(m_status & m_irqen)));
         check("model_rddata", rddata, want_rd);
      end
   end

   // Bus tasks are entered on a falling edge and return on a falling edge.
   task automatic wr(input int idx, input logic [31:0] data);
      addr = 8'(idx << 2); write = 1'b1; wrdata = data;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd(input int idx, output logic [31:0] data);
      addr = 8'(idx << 2);
      @(negedge clk);
      data = rddata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;
      int pat_p[4]  = '{1, 0, 0, 0};
      int pat_c[4]  = '{0, 0, 0, 1};
      int shd_p[8]  = '{0, 0, 1, 1, 1, 0, 1, 1};
      int shd_c[8]  = '{0, 1, 0, 0, 0, 1, 0, 0};

      #12;
      check("reset_pwm", 32'(pwm), 32'd0);
      check("reset_co", 32'(co), 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      check("reset_rddata", rddata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(I_INFO, d);
      check("info", d, 32'h2004_0000);

      // Basic PWM, period 4 duty 1.
      wr(I_P0, 4);
      wr(I_D0, 1);
      wr(I_CTRL, 32'h1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("basic_pwm0", 32'(pwm[0]), 32'(pat_p[k % 4]));
         check("basic_co0", 32'(co[0]), 32'(pat_c[k % 4]));
      end

      // Mid-period duty change takes effect at the next wrap.
      idle(1);
      wr(I_D0, 3);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("shadow_pwm0", 32'(pwm[0]), 32'(shd_p[k]));
         check("shadow_co0", 32'(co[0]), 32'(shd_c[k]));
      end

      // Polarity and duty/period boundaries.
      wr(I_CTRL, 32'h11);
      wr(I_D0, 0);
      idle(10);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("inv_duty0_pwm0", 32'(pwm[0]), 32'd1);
      end
      wr(I_D0, 5);
      idle(10);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("inv_dutybig_pwm0", 32'(pwm[0]), 32'd0);
      end
      wr(I_P0, 0);
      idle(10);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("per0_pwm0", 32'(pwm[0]), 32'd1);
         check("per0_co0", 32'(co[0]), 32'd0);
      end

      // Status / interrupt.
      wr(I_CTRL, 32'h0);
      wr(I_STATUS, 32'hF);
      wr(I_IRQ_EN, 32'h1);
      check("irq_idle", 32'(irq), 32'd0);
      wr(I_P0, 4);
      wr(I_D0, 1);
      wr(I_CTRL, 32'h1);
      idle(4);
      check("irq_first_co", 32'(irq), 32'd1);
      check("first_co0", 32'(co[0]), 32'd1);
      idle(3);
      wr(I_STATUS, 32'h1);
      check("irq_set_wins", 32'(irq), 32'd1);
      rd(I_STATUS, d);
      check("status_set_wins", d, 32'h1);
      wr(I_STATUS, 32'h1);
      check("irq_cleared", 32'(irq), 32'd0);
      @(negedge clk);
      check("irq_still_clear", 32'(irq), 32'd0);
      @(negedge clk);
      check("irq_next_co", 32'(irq), 32'd1);

      // Multi-channel independence.
      wr(I_CTRL, 32'h0);
      wr(I_STATUS, 32'hF);
      wr(I_IRQ_EN, 32'h0);
      wr(I_P0, 3);
      wr(I_D0, 1);
      wr(I_P1, 5);
      wr(I_D1, 2);
      wr(I_CTRL, 32'h23);
      idle(12);
      wr(I_CTRL, 32'h21);
      idle(3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("ch1_idle_pwm1", 32'(pwm[1]), 32'd1);
         check("ch1_idle_co1", 32'(co[1]), 32'd0);
      end
      rd(I_P1, d);
      check("read_period1", d, 32'd5);
      wr(I_UNMAPPED, 32'hFFFF_FFFF);
      rd(I_UNMAPPED, d);
      check("read_unmapped", d, 32'd0);

      // Asynchronous reset mid-period.
      wr(I_IRQ_EN, 32'h1);
      rd(I_INFO, d);
      idle(2);
      check("pre_reset_irq", 32'(irq), 32'd1);
      check("pre_reset_pwm1", 32'(pwm[1]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_pwm", 32'(pwm), 32'd0);
      check("async_reset_co", 32'(co), 32'd0);
      check("async_reset_irq", 32'(irq), 32'd0);
      check("async_reset_rddata", rddata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(I_CTRL, d);
      check("post_reset_ctrl", d, 32'd0);
      rd(I_INFO, d);
      check("post_reset_info", d, 32'h2004_0000);
      idle(4);
      check("post_reset_pwm", 32'(pwm), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pwm_multi_periph.md
Name: pwm_multi_periph

Overview:
- Multi-channel, parametrised PWM peripheral on the PicoMem memory-mapped slave bus; next generation of the single-channel period/duty PWM peripheral.
- Adds over the single-channel block:
  - CH independent channels with per-channel period/duty.
  - Shadow (double-buffered) period/duty, applied only at period wrap, for glitch-free updates.
  - Per-channel enable and output polarity.
  - Sticky carry-out status and a maskable interrupt.
- Sits beside other picomem peripherals; drives motor/LED outputs.

Parameters:
- CH, 4, number of PWM channels (1..16).
- W, 32, counter/period/duty width (2..32).
- ADDR_W, 8, byte-address width; requires 4+2*CH <= 2**(ADDR_W-2).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  byte address; word index = addr[ADDR_W-1:2].
- write  in  1  write strobe, one cycle per write.
- wrdata  in  32  write data.
- rddata  out  32  registered read data.
- pwm  out  CH  PWM outputs, registered.
- co  out  CH  one-cycle carry-out pulse per channel at period end.
- irq  out  1  level interrupt = |(STATUS & IRQ_EN).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). Register reset values:
  - all registers, counters and shadows 0; rddata=0, co=0, irq=0.
  - pwm=0 (polarity 0 after reset, so idle level 0).
- Register map (word index):
  - 0 CTRL: [CH-1:0] enable, [2CH-1:CH] invert; other bits read 0.
  - 1 STATUS: [CH-1:0] sticky co flags; write-1-to-clear.
  - 2 IRQ_EN: [CH-1:0].
  - 3 INFO (RO): {8'(W),8'(CH),16'h0}.
  - 4+2i PERIOD_i; 5+2i DUTY_i (programmed values, W bits, upper bits read 0).
  - Unmapped indices: reads 0, writes ignored.
- Read: rddata updated every clock edge from current addr (1-cycle latency, no read strobe). Write-then-read of the same register in the next cycle returns the new value.
- Per channel, in the active state (enable=1):
  - Counter cnt counts 0..per_a-1, then wraps to 0.
  - per_a/duty_a are shadow copies, loaded from PERIOD_i/DUTY_i on the wrap edge.
  - pwm_i <= ((cnt < duty_a) ^ inv_i), i.e. pwm lags cnt by one cycle.
  - co_i <= (cnt == per_a-1); STATUS_i set on the same edge.
- Enable transitions:
  - Enable 0->1 at edge E: cnt=0 and shadows loaded from the programmed registers at E.
  - Enable=0: cnt held at 0, pwm_i = inv_i (registered), co_i=0.
- Boundaries:
  - per_a=0: counter held at 0, pwm_i=inv_i, no co.
  - duty_a>=per_a (per_a>0): constant active level.
  - duty_a=0: constant inactive level.
  - per_a=1: co every cycle.
- Mid-period writes to PERIOD/DUTY: no effect on output until the next wrap.
- Simultaneous STATUS set and W1C on the same bit: set wins (flag stays 1).
- Counter uses W-bit unsigned arithmetic; compare per_a-1 only when per_a!=0 (no underflow).
- rst_n assertion mid-period: all outputs go to reset values immediately (asynchronous); operation restarts disabled.

Decomposition:
- Package pwm_multi_pkg: register index constants (CTRL, STATUS, IRQ_EN, INFO, CH_BASE=4), function ch_reg_idx(i,is_duty), INFO format constant.
- Sub-module pwm_channel (param W): enable, inv, programmed period/duty in; pwm, co out. Contains the counter, shadows and compare.
- Top: CH instances (generate), register file, read mux, STATUS/irq logic.

Test Plan:
- Reset check: assert rst_n=0 mid-run -> pwm=0, co=0, irq=0, rddata=0 immediately; read INFO after release -> 32'h2004_0000 (W=32, CH=4).
- Basic PWM: PERIOD_0=4, DUTY_0=1, CTRL=1 -> pwm[0] pattern 1,0,0,0 repeating from the second cycle after the enable write; co[0] one-cycle pulse every 4 cycles.
- Shadow update: while running, write DUTY_0=3 mid-period -> current period still 1-high; next period 3-high/1-low, with the change starting exactly at the wrap.
- Polarity/boundaries: CTRL inv_0=1, DUTY_0=0 -> pwm[0] constant 1; DUTY_0=5 with PERIOD_0=4 -> constant 0 after wrap; PERIOD_0=0 -> pwm[0]=inv, no co.
- Status/irq: IRQ_EN=1, run ch0 -> STATUS=1, irq=1; W1C STATUS=1 on the same cycle as co -> STATUS stays 1; W1C between pulses -> irq=0 until the next co.
- Multi-channel independence: ch0 period 3, ch1 period 5, ch1 disabled mid-run -> ch0 unaffected; pwm[1] idles at inv_1; read PERIOD_1 -> 5; unmapped index 63 reads 0.
